// File: rtl/wash_phase_timer_if.sv
// Wash phase timer bus: user controls and 1 Hz time base in, preset, countdown
// and status out. clk and rst stay plain ports on the timer itself.
interface wash_phase_timer_if #(
  parameter int WIDTH = 7
);
  logic             clk_1hz;
  logic             start;
  logic             pause;
  logic             upkey;
  logic             downkey;
  logic [WIDTH-1:0] settimer;
  logic [WIDTH-1:0] remaining;
  logic [1:0]       state;
  logic             running;
  logic             done;

  // Controller side (panel / testbench) drives the keys and time base.
  modport master (
    output clk_1hz, start, pause, upkey, downkey,
    input  settimer, remaining, state, running, done
  );

  // Timer side.
  modport slave (
    input  clk_1hz, start, pause, upkey, downkey,
    output settimer, remaining, state, running, done
  );
endinterface

// File: rtl/wash_phase_timer.sv
// Wash phase countdown timer.
// A preset (adjustable only in IDLE) is loaded into a seconds counter on start;
// the counter decrements on each synchronised clk_1hz rising edge until DONE.
// Optional feature macro: WASH_TIMER_KEY_REPEAT_EN -- in IDLE, a key held for
// two ticks keeps stepping the preset once per further tick.
module wash_phase_timer #(
  parameter int WIDTH     = 7,
  parameter int T_DEFAULT = 50,
  parameter int T_MIN     = 1,
  parameter int T_MAX     = 99,
  parameter int STEP      = 1
) (
  input  logic                clk,
  input  logic                rst,    // asynchronous, active-low
  wash_phase_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] DEF_W  = WIDTH'(T_DEFAULT);
  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(T_MIN);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(T_MAX);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  // Input conditioning state.
  logic       hz_s1_q, hz_s2_q, hz_prev_q;
  logic       start_prev_q, pause_prev_q, up_prev_q, down_prev_q;
  logic [1:0] warm_q;   // clocks since reset release, saturating at 3

  // Core state.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic             running_q, done_q;

  logic tick, start_ev, pause_ev, up_ev, down_ev;
  logic up_rep, down_rep, up_adj, down_adj;

  // The edge detectors come out of reset at 0. Events are held off until the
  // registered copies have sampled real input levels, so a key or clk_1hz held
  // high through reset release is not mistaken for a rising edge.
  assign tick     = hz_s2_q & ~hz_prev_q & (warm_q == 2'd3);
  assign start_ev = bus.start   & ~start_prev_q & (warm_q != 2'd0);
  assign pause_ev = bus.pause   & ~pause_prev_q & (warm_q != 2'd0);
  assign up_ev    = bus.upkey   & ~up_prev_q    & (warm_q != 2'd0);
  assign down_ev  = bus.downkey & ~down_prev_q  & (warm_q != 2'd0);

  // Synchronise clk_1hz and register key levels for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hz_s1_q      <= 1'b0;
      hz_s2_q      <= 1'b0;
      hz_prev_q    <= 1'b0;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
      up_prev_q    <= 1'b0;
      down_prev_q  <= 1'b0;
      warm_q       <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, which is what turns these three lines into a real shift chain.
      hz_s1_q      <= bus.clk_1hz;
      hz_s2_q      <= hz_s1_q;
      hz_prev_q    <= hz_s2_q;
      start_prev_q <= bus.start;
      pause_prev_q <= bus.pause;
      up_prev_q    <= bus.upkey;
      down_prev_q  <= bus.downkey;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

`ifdef WASH_TIMER_KEY_REPEAT_EN
  logic [1:0] up_hold_q, down_hold_q;
  logic       up_held, down_held;

  // A key counts as held only while the other key is released.
  assign up_held   = bus.upkey   & up_prev_q   & ~bus.downkey;
  assign down_held = bus.downkey & down_prev_q & ~bus.upkey;
  assign up_rep    = up_held   & tick & (up_hold_q   == 2'd2) & (state_q == IDLE);
  assign down_rep  = down_held & tick & (down_hold_q == 2'd2) & (state_q == IDLE);

  // Count ticks a key has been held in IDLE; repeats start after the second.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_hold_q   <= 2'd0;
      down_hold_q <= 2'd0;
    end else begin
      if (!up_held || state_q != IDLE)        up_hold_q   <= 2'd0;
      else if (tick && up_hold_q != 2'd2)     up_hold_q   <= up_hold_q + 2'd1;
      if (!down_held || state_q != IDLE)      down_hold_q <= 2'd0;
      else if (tick && down_hold_q != 2'd2)   down_hold_q <= down_hold_q + 2'd1;
    end
  end
`else
  assign up_rep   = 1'b0;
  assign down_rep = 1'b0;
`endif

  assign up_adj   = up_ev   | up_rep;
  assign down_adj = down_ev | down_rep;

  // Register state, preset, countdown and the decoded status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      preset_q    <= DEF_W;
      remaining_q <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      preset_q    <= preset_d;
      remaining_q <= remaining_d;
      running_q   <= (state_d == RUN);
      done_q      <= (state_d == DONE);
    end
  end

  // Next-state, preset adjustment and countdown.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d     = state_q;
    preset_d    = preset_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (up_adj && !down_adj) begin
          preset_d = (int'(preset_q) > T_MAX - STEP) ? MAX_W : preset_q + STEP_W;
        end else if (down_adj && !up_adj) begin
          preset_d = (int'(preset_q) < T_MIN + STEP) ? MIN_W : preset_q - STEP_W;
        end
        if (start_ev) begin
          remaining_d = preset_q;
          state_d     = RUN;
        end
      end
      RUN: begin
        // The tick decrement applies before pause; reaching 0 beats pause.
        if (tick) begin
          if (remaining_q <= ONE_W) begin
            remaining_d = '0;
            state_d     = DONE;
          end else begin
            remaining_d = remaining_q - ONE_W;
          end
        end
        if (state_d == RUN && pause_ev) state_d = PAUSE;
      end
      PAUSE: begin
        if (start_ev) state_d = RUN;
      end
      DONE: begin
        remaining_d = '0;
        if (start_ev) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.settimer  = preset_q;
  assign bus.remaining = remaining_q;
  assign bus.state     = state_q;
  assign bus.running   = running_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer: reset values, preset saturation,
// countdown to DONE, pause/resume, same-cycle collisions, mid-run reset,
// keys held through reset, and key hold behaviour (repeat or no repeat).
module tb_wash_phase_timer;

  localparam int K_UP = 0, K_DOWN = 1, K_START = 2, K_PAUSE = 3, K_BOTH = 4, K_SP = 5;
`ifdef WASH_TIMER_KEY_REPEAT_EN
  localparam int HOLD_UP_EXP = 54;
`else
  localparam int HOLD_UP_EXP = 51;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec  = 0;
  int   n_fail = 0;

  wash_phase_timer_if #(.WIDTH(7)) bus ();

  wash_phase_timer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  // Pulse one key (or a key pair) high for one clk; called at a negedge.
  task automatic press(input int k);
    case (k)
      K_UP:    bus.upkey = 1'b1;
      K_DOWN:  bus.downkey = 1'b1;
      K_START: bus.start = 1'b1;
      K_PAUSE: bus.pause = 1'b1;
      K_BOTH:  begin bus.upkey = 1'b1; bus.downkey = 1'b1; end
      default: begin bus.start = 1'b1; bus.pause = 1'b1; end
    endcase
    @(negedge clk);
    bus.upkey = 1'b0; bus.downkey = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    @(negedge clk);
  endtask

  // One clk_1hz period: high long enough to pass the synchroniser, then low.
  task automatic do_tick();
    bus.clk_1hz = 1'b1;
    repeat (4) @(negedge clk);
    bus.clk_1hz = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    if (bus.settimer !== 7'd50) begin n_fail++; $display("FAIL rst_settimer: got %0d want 50", bus.settimer); end n_vec++;
    if (bus.remaining !== 7'd0) begin n_fail++; $display("FAIL rst_remaining: got %0d want 0", bus.remaining); end n_vec++;
    if (bus.state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", bus.state); end n_vec++;
    if (bus.running !== 1'b0) begin n_fail++; $display("FAIL rst_running: got %0b want 0", bus.running); end n_vec++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", bus.done); end n_vec++;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    if (bus.settimer !== 7'd50 || bus.state !== 2'd0) begin n_fail++; $display("FAIL post_rst: got settimer=%0d state=%0d want 50/0", bus.settimer, bus.state); end n_vec++;
  endtask

  task automatic test_preset_saturation();
    int exp_p = 50;
    for (int i = 0; i < 60; i++) begin
      press(K_UP);
      exp_p = (exp_p + 1 > 99) ? 99 : exp_p + 1;
      if (bus.settimer !== 7'(exp_p)) begin n_fail++; $display("FAIL up_step%0d: got %0d want %0d", i, bus.settimer, exp_p); end n_vec++;
    end
    for (int i = 0; i < 120; i++) begin
      press(K_DOWN);
      exp_p = (exp_p - 1 < 1) ? 1 : exp_p - 1;
      if (bus.settimer !== 7'(exp_p)) begin n_fail++; $display("FAIL down_step%0d: got %0d want %0d", i, bus.settimer, exp_p); end n_vec++;
    end
    press(K_UP);
    press(K_UP);
    if (bus.settimer !== 7'd3) begin n_fail++; $display("FAIL preset3: got %0d want 3", bus.settimer); end n_vec++;
    press(K_BOTH);
    if (bus.settimer !== 7'd3) begin n_fail++; $display("FAIL both_keys: got %0d want 3", bus.settimer); end n_vec++;
  endtask

  task automatic test_run_to_done();
    press(K_START);
    if (bus.state !== 2'd1 || bus.running !== 1'b1) begin n_fail++; $display("FAIL run_enter: got state=%0d running=%0b want 1/1", bus.state, bus.running); end n_vec++;
    if (bus.remaining !== 7'd3) begin n_fail++; $display("FAIL run_load: got %0d want 3", bus.remaining); end n_vec++;
    press(K_UP);
    if (bus.settimer !== 7'd3) begin n_fail++; $display("FAIL adj_in_run: got %0d want 3", bus.settimer); end n_vec++;
    for (int i = 1; i <= 3; i++) begin
      do_tick();
      if (bus.remaining !== 7'(3 - i)) begin n_fail++; $display("FAIL count%0d: got %0d want %0d", i, bus.remaining, 3 - i); end n_vec++;
    end
    if (bus.state !== 2'd3 || bus.done !== 1'b1 || bus.running !== 1'b0) begin n_fail++; $display("FAIL done_flags: got state=%0d done=%0b running=%0b want 3/1/0", bus.state, bus.done, bus.running); end n_vec++;
    do_tick();
    if (bus.remaining !== 7'd0 || bus.state !== 2'd3) begin n_fail++; $display("FAIL done_hold: got rem=%0d state=%0d want 0/3", bus.remaining, bus.state); end n_vec++;
    press(K_START);
    if (bus.state !== 2'd0 || bus.settimer !== 7'd3 || bus.done !== 1'b0) begin n_fail++; $display("FAIL ack_idle: got state=%0d settimer=%0d done=%0b want 0/3/0", bus.state, bus.settimer, bus.done); end n_vec++;
  endtask

  task automatic test_pause_resume();
    repeat (7) press(K_UP);
    if (bus.settimer !== 7'd10) begin n_fail++; $display("FAIL preset10: got %0d want 10", bus.settimer); end n_vec++;
    press(K_START);
    repeat (4) do_tick();
    if (bus.remaining !== 7'd6) begin n_fail++; $display("FAIL before_pause: got %0d want 6", bus.remaining); end n_vec++;
    press(K_PAUSE);
    if (bus.state !== 2'd2 || bus.running !== 1'b0) begin n_fail++; $display("FAIL pause_enter: got state=%0d running=%0b want 2/0", bus.state, bus.running); end n_vec++;
    repeat (5) do_tick();
    if (bus.remaining !== 7'd6 || bus.state !== 2'd2) begin n_fail++; $display("FAIL pause_hold: got rem=%0d state=%0d want 6/2", bus.remaining, bus.state); end n_vec++;
    press(K_START);
    if (bus.state !== 2'd1) begin n_fail++; $display("FAIL resume: got %0d want 1", bus.state); end n_vec++;
    repeat (5) do_tick();
    if (bus.remaining !== 7'd1 || bus.state !== 2'd1) begin n_fail++; $display("FAIL resume_count: got rem=%0d state=%0d want 1/1", bus.remaining, bus.state); end n_vec++;
    do_tick();
    if (bus.remaining !== 7'd0 || bus.state !== 2'd3) begin n_fail++; $display("FAIL resume_done: got rem=%0d state=%0d want 0/3", bus.remaining, bus.state); end n_vec++;
    press(K_START);
  endtask

  task automatic test_collisions();
    press(K_START);
    repeat (9) do_tick();
    if (bus.remaining !== 7'd1) begin n_fail++; $display("FAIL pre_collide: got %0d want 1", bus.remaining); end n_vec++;
    // The tick reaches the core on the third clk edge after clk_1hz rises;
    // the pause edge is placed on that same edge.
    bus.clk_1hz = 1'b1;
    repeat (2) @(negedge clk);
    bus.pause = 1'b1;
    @(negedge clk);
    bus.pause = 1'b0;
    if (bus.state !== 2'd3 || bus.remaining !== 7'd0) begin n_fail++; $display("FAIL tick_pause: got state=%0d rem=%0d want 3/0", bus.state, bus.remaining); end n_vec++;
    bus.clk_1hz = 1'b0;
    repeat (4) @(negedge clk);
    press(K_START);
    press(K_START);
    press(K_SP);
    if (bus.state !== 2'd2) begin n_fail++; $display("FAIL start_pause: got %0d want 2", bus.state); end n_vec++;
    press(K_START);
  endtask

  task automatic test_reset_midrun();
    repeat (3) do_tick();
    if (bus.remaining !== 7'd7 || bus.state !== 2'd1) begin n_fail++; $display("FAIL pre_reset: got rem=%0d state=%0d want 7/1", bus.remaining, bus.state); end n_vec++;
    rst = 1'b0;
    bus.upkey = 1'b1; bus.start = 1'b1; bus.clk_1hz = 1'b1;
    #1;
    if (bus.state !== 2'd0 || bus.remaining !== 7'd0 || bus.settimer !== 7'd50) begin n_fail++; $display("FAIL midrun_rst: got state=%0d rem=%0d settimer=%0d want 0/0/50", bus.state, bus.remaining, bus.settimer); end n_vec++;
    if (bus.running !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL midrun_flags: got running=%0b done=%0b want 0/0", bus.running, bus.done); end n_vec++;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    if (bus.state !== 2'd0 || bus.settimer !== 7'd50 || bus.remaining !== 7'd0) begin n_fail++; $display("FAIL held_thru_rst: got state=%0d settimer=%0d rem=%0d want 0/50/0", bus.state, bus.settimer, bus.remaining); end n_vec++;
    bus.upkey = 1'b0; bus.start = 1'b0; bus.clk_1hz = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_key_hold();
    bus.upkey = 1'b1;
    @(negedge clk);
    repeat (5) do_tick();
    bus.upkey = 1'b0;
    @(negedge clk);
    if (bus.settimer !== 7'(HOLD_UP_EXP)) begin n_fail++; $display("FAIL hold_up: got %0d want %0d", bus.settimer, HOLD_UP_EXP); end n_vec++;
    bus.upkey = 1'b1; bus.downkey = 1'b1;
    @(negedge clk);
    repeat (5) do_tick();
    bus.upkey = 1'b0; bus.downkey = 1'b0;
    @(negedge clk);
    if (bus.settimer !== 7'(HOLD_UP_EXP)) begin n_fail++; $display("FAIL hold_both: got %0d want %0d", bus.settimer, HOLD_UP_EXP); end n_vec++;
  endtask

  initial begin
    bus.clk_1hz = 1'b0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.upkey = 1'b0; bus.downkey = 1'b0;
    test_reset();
    test_preset_saturation();
    test_run_to_done();
    test_pause_resume();
    test_collisions();
    test_reset_midrun();
    test_key_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wash_phase_timer.md
WASH_PHASE_TIMER -- requirements
Module: wash_phase_timer

Interface
REQ-001 SHALL: WIDTH, 7, bit width of preset and remaining-time values.
REQ-002 SHALL: T_DEFAULT, 50, preset value loaded at reset.
REQ-003 SHALL: T_MIN, 1, lowest allowed preset; must be at least 1.
REQ-004 SHALL: T_MAX, 99, highest allowed preset; T_MIN <= T_DEFAULT <= T_MAX < 2^WIDTH.
REQ-005 SHALL: STEP, 1, preset increment/decrement per key edge.
REQ-006 SHALL: clk  input  1  single system clock; all logic on posedge clk.
REQ-007 SHALL: rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL: clk_1hz  input  1  slow time base, asynchronous to clk.
REQ-009 SHALL: start  input  1  level; rising edge starts, resumes or acknowledges.
REQ-010 SHALL: pause  input  1  level; rising edge pauses a running cycle.
REQ-011 SHALL: upkey  input  1  level; rising edge raises the preset.
REQ-012 SHALL: downkey  input  1  level; rising edge lowers the preset.
REQ-013 SHALL: settimer  output  WIDTH  current preset.
REQ-014 SHALL: remaining  output  WIDTH  seconds left in the current cycle.
REQ-015 SHALL: state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-016 SHALL: running  output  1  high only in RUN.
REQ-017 SHALL: done  output  1  high only in DONE.

Function
REQ-018 SHALL: clk_1hz passes through a 2-flop synchroniser; its rising edge yields a one-clk tick, 3 clk after the input edge at most.
REQ-019 SHALL: start, pause, upkey and downkey are each edge-detected against a registered copy; one edge gives a one-clk event.
REQ-020 SHALL: in IDLE, an up event sets preset to min(preset+STEP, T_MAX) and a down event sets it to max(preset-STEP, T_MIN).
  - Saturates; never wraps.
  - Up and down events in the same cycle leave the preset unchanged.
REQ-021 SHALL: preset adjustment is ignored in RUN, PAUSE and DONE.
REQ-022 SHALL: a start event in IDLE loads remaining with the preset and enters RUN on the next clk.
REQ-023 SHALL: in RUN, each tick decrements remaining by 1.
  - When a tick takes remaining to 0, the block enters DONE in the same update.
REQ-024 SHALL: a pause event in RUN enters PAUSE.
  - If a tick occurs in the same cycle, the decrement applies first.
  - If that decrement reaches 0, DONE wins over PAUSE.
REQ-025 SHALL: start and pause events together in RUN resolve as pause.
REQ-026 SHALL: in PAUSE, ticks are ignored and remaining holds; a start event returns to RUN.
REQ-027 SHALL: in DONE, remaining stays 0; a start event returns to IDLE with the preset retained.
REQ-028 SHALL: outputs are registered, so state, running, done and remaining change 1 clk after the causing event.

Reset
REQ-029 SHALL: asserting rst (low) immediately forces:
  - preset = T_DEFAULT, remaining = 0, state = IDLE, running = 0, done = 0;
  - all edge-detect and synchroniser flops = 0.
REQ-030 SHALL: reset asserted mid-cycle (RUN or PAUSE) aborts the cycle with no tick or done pulse afterwards.
REQ-031 SHALL: a key or clk_1hz held high through reset release creates no event until it falls and rises again.

Configuration
REQ-032 SHALL: macro WASH_TIMER_KEY_REPEAT_EN enables key auto-repeat.
  - With it defined: in IDLE, a key held high for 2 consecutive ticks repeats its STEP adjustment on every further tick while held.
  - Both keys held together give no repeat.
  - Without it: exactly one adjustment per rising edge, and hold time has no effect.

Verification
REQ-033 SHALL: reset release with defaults -> settimer=50, remaining=0, state=IDLE, running=0, done=0.
REQ-034 SHALL: 60 upkey edges from 50 -> settimer saturates at 99; 120 downkey edges -> settimer=1, never 0 or 127.
REQ-035 SHALL: preset=3, start edge, 3 clk_1hz edges -> remaining goes 3,2,1,0; done=1 and state=DONE after the third tick; start edge -> IDLE, settimer=3.
REQ-036 SHALL: preset=10, start, 4 ticks, pause, 5 ticks, start, 6 ticks -> remaining=6 during PAUSE, then DONE after 6 further ticks.
REQ-037 SHALL: remaining=1 with pause and tick in the same clk -> state=DONE, not PAUSE; start and pause together in RUN -> PAUSE.
REQ-038 SHALL: rst asserted in RUN with remaining=7 -> state=IDLE, remaining=0, settimer=50 immediately; with WASH_TIMER_KEY_REPEAT_EN, upkey held 5 ticks from 50 -> settimer=54.
